// File: rtl/pc_fetch.sv
// ---------------------------------------------------------------------------
// pc_fetch -- instruction-fetch program counter with an optional branch
// target buffer (BTB) for next-PC prediction.
//
// Optional feature macro: PC_BTB_EN
//   defined   : a direct-mapped BTB (2^BTB_IDX_W entries) with 2-bit
//               saturating counters is built and drives PredTaken.
//   undefined : no BTB storage, PredTaken is tied low and the branch
//               update inputs are ignored.
//
// Parameters
//   RESET_PC   PC value loaded on reset (low two bits are dropped)
//   BTB_IDX_W  BTB index width
//
// Ports
//   clk        single clock, all state updates on its rising edge
//   rst        synchronous active-high reset
//   PCWr       PC write enable (0 = hold the PC)
//   NPCSrc     redirect request, 1 = load NPC
//   NPC        redirect target from ID
//   BrUpdate   one-cycle pulse: a branch in ID has resolved
//   BrPC       PC of the resolved branch
//   BrTaken    resolved direction (1 = taken)
//   BrTarget   resolved taken-target
//   PC         current fetch address (registered)
//   PCPLUS4    PC + 4 (combinational, wraps modulo 2^32)
//   PredTaken  BTB predicts the current PC is a taken branch
// ---------------------------------------------------------------------------
module pc_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int          BTB_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWr,
  input  logic        NPCSrc,
  input  logic [31:0] NPC,
  input  logic        BrUpdate,
  input  logic [31:0] BrPC,
  input  logic        BrTaken,
  input  logic [31:0] BrTarget,
  output logic [31:0] PC,
  output logic [31:0] PCPLUS4,
  output logic        PredTaken
);

  // Only word-aligned addresses are stored; bits [1:0] are implicitly zero.
  logic [31:2] pc_reg;
  logic [31:2] pc_next;

  // Prediction for the current PC (tied off when the BTB is not built).
  logic        pred_taken;
  logic [31:2] pred_target;

  assign PC        = {pc_reg, 2'b00};
  assign PCPLUS4   = PC + 32'd4;
  assign PredTaken = pred_taken;

`ifdef PC_BTB_EN
  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int TAG_W = 30 - BTB_IDX_W;

  // Lookup uses the current fetch PC, update uses the resolved branch PC.
  logic [BTB_IDX_W-1:0] lu_idx;
  logic [TAG_W-1:0]     lu_tag;
  logic [BTB_IDX_W-1:0] br_idx;
  logic [TAG_W-1:0]     br_tag;

  assign lu_idx = pc_reg[BTB_IDX_W+1:2];
  assign lu_tag = pc_reg[31:BTB_IDX_W+2];
  assign br_idx = BrPC[BTB_IDX_W+1:2];
  assign br_tag = BrPC[31:BTB_IDX_W+2];

  // Read-side views of every entry, each element driven by its own entry.
  logic [BTB_N-1:0] valid_vec;
  logic [TAG_W-1:0] tag_arr    [BTB_N];
  logic [31:2]      target_arr [BTB_N];
  logic [1:0]       ctr_arr    [BTB_N];

  genvar gi;
  generate
    for (gi = 0; gi < BTB_N; gi++) begin : g_entry
      logic             valid_reg;
      logic [TAG_W-1:0] tag_reg;
      logic [31:2]      target_reg;
      logic [1:0]       ctr_reg;
      logic             sel;
      logic             upd_hit;

      assign sel     = BrUpdate && (br_idx == BTB_IDX_W'(gi));
      assign upd_hit = valid_reg && (tag_reg == br_tag);

      // Valid and counter are reset; tag/target are don't-care while the
      // entry is invalid, so they carry no reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg <= 1'b0;
          ctr_reg   <= 2'b01;
        end else if (sel) begin
          if (upd_hit) begin
            if (BrTaken) begin
              if (ctr_reg != 2'b11) begin
                ctr_reg <= ctr_reg + 2'b01;
              end
              target_reg <= BrTarget[31:2];
            end else if (ctr_reg != 2'b00) begin
              ctr_reg <= ctr_reg - 2'b01;
            end
          end else if (BrTaken) begin
            // Miss on a taken branch: allocate, evicting any prior occupant,
            // starting weakly taken so the next fetch predicts it.
            valid_reg  <= 1'b1;
            tag_reg    <= br_tag;
            target_reg <= BrTarget[31:2];
            ctr_reg    <= 2'b10;
          end
        end
      end

      assign valid_vec[gi]  = valid_reg;
      assign tag_arr[gi]    = tag_reg;
      assign target_arr[gi] = target_reg;
      assign ctr_arr[gi]    = ctr_reg;
    end
  endgenerate

  // Reads see the registered contents, so an update in this cycle only
  // becomes visible to lookups from the next cycle on.
  assign pred_taken  = valid_vec[lu_idx] && (tag_arr[lu_idx] == lu_tag)
                       && ctr_arr[lu_idx][1];
  assign pred_target = target_arr[lu_idx];

  // Byte-offset bits are forced to zero and therefore never read.
  logic unused_low_bits;
  assign unused_low_bits = ^{NPC[1:0], BrPC[1:0], BrTarget[1:0]};
`else
  assign pred_taken  = 1'b0;
  assign pred_target = '0;

  // Branch resolution has no effect without a BTB.
  logic unused_branch_inputs;
  assign unused_branch_inputs = ^{NPC[1:0], BrUpdate, BrPC, BrTaken, BrTarget};
`endif

  // Next-PC priority: hold > redirect > prediction > sequential.
  always_comb begin
    pc_next = pc_reg;
    if (!PCWr) begin
      pc_next = pc_reg;
    end else if (NPCSrc) begin
      pc_next = NPC[31:2];
    end else if (pred_taken) begin
      pc_next = pred_target;
    end else begin
      pc_next = PCPLUS4[31:2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= RESET_PC[31:2];
    end else begin
      pc_reg <= pc_next;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch -- directed scoreboard bench for pc_fetch.
// Each step drives one cycle of inputs and queues the PC / PCPLUS4 /
// PredTaken values expected after that rising edge; a monitor compares
// them on the following falling edge. BTB-specific steps are built only
// when PC_BTB_EN is defined, matching the DUT build.
// ---------------------------------------------------------------------------
module tb_pc_fetch;

  logic        clk;
  logic        rst;
  logic        PCWr;
  logic        NPCSrc;
  logic [31:0] NPC;
  logic        BrUpdate;
  logic [31:0] BrPC;
  logic        BrTaken;
  logic [31:0] BrTarget;
  logic [31:0] PC;
  logic [31:0] PCPLUS4;
  logic        PredTaken;

  pc_fetch #(
    .RESET_PC (32'h0000_3000),
    .BTB_IDX_W(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .PCWr     (PCWr),
    .NPCSrc   (NPCSrc),
    .NPC      (NPC),
    .BrUpdate (BrUpdate),
    .BrPC     (BrPC),
    .BrTaken  (BrTaken),
    .BrTarget (BrTarget),
    .PC       (PC),
    .PCPLUS4  (PCPLUS4),
    .PredTaken(PredTaken)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        pred;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_no  = 0;
  bit   stim_done = 1'b0;

  // Monitor: one line per transaction, FAIL lines on any mismatch.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (PC !== e.pc) begin
        failures++;
        $display("FAIL step%0d pc: got %h expected %h", e.id, PC, e.pc);
      end
      checks++;
      if (PCPLUS4 !== e.pc4) begin
        failures++;
        $display("FAIL step%0d pcplus4: got %h expected %h", e.id, PCPLUS4, e.pc4);
      end
      checks++;
      if (PredTaken !== e.pred) begin
        failures++;
        $display("FAIL step%0d predtaken: got %b expected %b", e.id, PredTaken, e.pred);
      end
      $display("txn %0d: PC=%h PCPLUS4=%h PredTaken=%b", e.id, PC, PCPLUS4, PredTaken);
    end
  end

  task automatic step(input logic r, input logic wr, input logic ns,
                      input logic [31:0] npc, input logic bu,
                      input logic [31:0] bpc, input logic bt,
                      input logic [31:0] btg, input logic [31:0] exp_pc,
                      input logic exp_pred);
    exp_t e;
    rst = r; PCWr = wr; NPCSrc = ns; NPC = npc;
    BrUpdate = bu; BrPC = bpc; BrTaken = bt; BrTarget = btg;
    @(posedge clk);
    step_no++;
    e.id   = step_no;
    e.pc   = exp_pc;
    e.pc4  = exp_pc + 32'd4;
    e.pred = exp_pred;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic adv(input logic [31:0] exp_pc, input logic exp_pred);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, exp_pc, exp_pred);
  endtask

  task automatic redir(input logic [31:0] npc, input logic [31:0] exp_pc,
                       input logic exp_pred);
    step(1'b0, 1'b1, 1'b1, npc, 1'b0, 32'h0, 1'b0, 32'h0, exp_pc, exp_pred);
  endtask

  task automatic upd(input logic [31:0] bpc, input logic bt, input logic [31:0] btg,
                     input logic [31:0] exp_pc, input logic exp_pred);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, bpc, bt, btg, exp_pc, exp_pred);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; PCWr = 1'b0; NPCSrc = 1'b0; NPC = 32'h0;
    BrUpdate = 1'b0; BrPC = 32'h0; BrTaken = 1'b0; BrTarget = 32'h0;

    // Reset then sequential fetch.
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_3000, 1'b0);
    adv(32'h0000_3004, 1'b0);
    adv(32'h0000_3008, 1'b0);
    // Stall dominates a pending redirect, then the redirect is taken.
    step(1'b0, 1'b0, 1'b1, 32'h4000, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_3008, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h4000, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_3008, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h4000, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_3008, 1'b0);
    redir(32'h0000_4000, 32'h0000_4000, 1'b0);
    // Misaligned redirect target is forced to a word boundary.
    redir(32'h0000_5003, 32'h0000_5000, 1'b0);
    adv(32'h0000_5004, 1'b0);
    // Wrap-around at the top of the address space.
    redir(32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b0);
    adv(32'h0000_0000, 1'b0);
    // Reset beats a simultaneous taken-branch update; no entry appears.
    step(1'b1, 1'b1, 1'b1, 32'h7000, 1'b1, 32'h3000, 1'b1, 32'h3200, 32'h0000_3000, 1'b0);
    adv(32'h0000_3004, 1'b0);

`ifdef PC_BTB_EN
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_3000, 1'b0);
    // Allocate 0x3010 -> 0x3100 and fetch into it.
    upd(32'h0000_3010, 1'b1, 32'h0000_3100, 32'h0000_3004, 1'b0);
    adv(32'h0000_3008, 1'b0);
    adv(32'h0000_300C, 1'b0);
    adv(32'h0000_3010, 1'b1);
    adv(32'h0000_3100, 1'b0);
    // Two not-taken updates: 10 -> 01 -> 00, prediction lost.
    upd(32'h0000_3010, 1'b0, 32'h0, 32'h0000_3104, 1'b0);
    upd(32'h0000_3010, 1'b0, 32'h0, 32'h0000_3108, 1'b0);
    redir(32'h0000_3010, 32'h0000_3010, 1'b0);
    adv(32'h0000_3014, 1'b0);
    // Third not-taken saturates at 00: one taken brings it only to 01.
    upd(32'h0000_3010, 1'b0, 32'h0, 32'h0000_3018, 1'b0);
    upd(32'h0000_3010, 1'b1, 32'h0000_3100, 32'h0000_301C, 1'b0);
    redir(32'h0000_3010, 32'h0000_3010, 1'b0);
    // Second taken reaches 10 and retargets the entry to 0x3200.
    upd(32'h0000_3010, 1'b1, 32'h0000_3200, 32'h0000_3014, 1'b0);
    redir(32'h0000_3010, 32'h0000_3010, 1'b1);
    adv(32'h0000_3200, 1'b0);
    // Alias: 0x3050 shares the index and evicts 0x3010.
    upd(32'h0000_3050, 1'b1, 32'h0000_3300, 32'h0000_3204, 1'b0);
    redir(32'h0000_3010, 32'h0000_3010, 1'b0);
    adv(32'h0000_3014, 1'b0);
    redir(32'h0000_3050, 32'h0000_3050, 1'b1);
    // Redirect beats prediction.
    redir(32'h0000_3400, 32'h0000_3400, 1'b0);
    redir(32'h0000_3050, 32'h0000_3050, 1'b1);
    // Same-cycle lookup/update: pre-update prediction is used.
    upd(32'h0000_3050, 1'b0, 32'h0, 32'h0000_3300, 1'b0);
    redir(32'h0000_3050, 32'h0000_3050, 1'b0);
    adv(32'h0000_3054, 1'b0);
    upd(32'h0000_3050, 1'b1, 32'h0000_3300, 32'h0000_3058, 1'b0);
    redir(32'h0000_3050, 32'h0000_3050, 1'b1);
    // Reset with a simultaneous update clears the BTB and writes nothing.
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h3000, 1'b1, 32'h3500, 32'h0000_3000, 1'b0);
    // Update while stalled still writes; visible next cycle at held PC.
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3000, 1'b1, 32'h3500, 32'h0000_3000, 1'b1);
    adv(32'h0000_3500, 1'b0);
    redir(32'h0000_3050, 32'h0000_3050, 1'b0);
    adv(32'h0000_3054, 1'b0);
`else
    // Without a BTB, branch updates have no effect on fetch.
    upd(32'h0000_3008, 1'b1, 32'h0000_3100, 32'h0000_3008, 1'b0);
    adv(32'h0000_300C, 1'b0);
    adv(32'h0000_3010, 1'b0);
`endif

    stim_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
